// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall with timeout abort, load-use bubble,
// branch/jump redirect gating and a saturating stall-cycle counter.
`ifndef REG_FILE_ADDR_WIDTH
`define REG_FILE_ADDR_WIDTH 5
`endif

module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            reg_1_valid,
    input  logic                            reg_2_valid,
    input  logic [`REG_FILE_ADDR_WIDTH-1:0] id_reg_1_idx,
    input  logic [`REG_FILE_ADDR_WIDTH-1:0] id_reg_2_idx,
    input  logic                            ex_mem_read,
    input  logic [`REG_FILE_ADDR_WIDTH-1:0] ex_reg_dest_idx,
    input  logic                            pc_offset,
    input  logic                            pc_overload,
    input  logic                            mem_req,
    input  logic                            mem_ready,
    output logic                            pc_hold,
    output logic                            if_id_hold,
    output logic                            if_id_flush,
    output logic                            id_ex_hold,
    output logic                            id_ex_flush,
    output logic                            ex_mem_hold,
    output logic                            ex_mem_flush,
    output logic                            redirect_en,
    output logic                            mem_timeout,
    output logic [15:0]                     stall_cycles,
    output logic [1:0]                      state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ABORT = 2'b10,
        ST_BAD   = 2'b11
    } state_e;

    localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] stall_q, stall_d;

    logic mem_stall;
    logic load_use;
    logic pc_hold_c, if_id_hold_c, if_id_flush_c, id_ex_hold_c, id_ex_flush_c;
    logic ex_mem_hold_c, ex_mem_flush_c, redirect_en_c, mem_timeout_c;

    always_comb begin
        mem_stall = mem_req & ~mem_ready & ((state_q == ST_RUN) | (state_q == ST_WAIT));
        load_use  = ex_mem_read & (ex_reg_dest_idx != '0) &
                    ((reg_1_valid & (id_reg_1_idx == ex_reg_dest_idx)) |
                     (reg_2_valid & (id_reg_2_idx == ex_reg_dest_idx)));
    end

    always_comb begin
        pc_hold_c      = 1'b0;
        if_id_hold_c   = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_hold_c   = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_hold_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        redirect_en_c  = 1'b0;
        mem_timeout_c  = 1'b0;
        state_d        = state_q;
        tmo_d          = tmo_q;

        case (state_q)
            ST_RUN, ST_WAIT: begin
                if (mem_stall) begin
                    pc_hold_c     = 1'b1;
                    if_id_hold_c  = 1'b1;
                    id_ex_hold_c  = 1'b1;
                    ex_mem_hold_c = 1'b1;
                end else if (load_use) begin
                    pc_hold_c     = 1'b1;
                    if_id_hold_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else begin
                    redirect_en_c = 1'b1;
                    if_id_flush_c = pc_offset | pc_overload;
                end

                if (state_q == ST_RUN) begin
                    if (mem_stall) begin
                        state_d = ST_WAIT;
                        tmo_d   = '0;
                    end
                end else if (mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    // Counter holds the number of completed WAIT cycles; abort once this one makes TIMEOUT_CYCLES.
                    tmo_d = tmo_q + 8'd1;
                    if (({1'b0, tmo_q} + 9'd1) >= TMO_LIMIT) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                mem_timeout_c  = 1'b1;
                ex_mem_flush_c = 1'b1;
                if (load_use) begin
                    pc_hold_c     = 1'b1;
                    if_id_hold_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                end
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset must silence controls immediately, not just at the next edge.
    always_comb begin
        pc_hold      = rst_n & pc_hold_c;
        if_id_hold   = rst_n & if_id_hold_c;
        if_id_flush  = rst_n & if_id_flush_c;
        id_ex_hold   = rst_n & id_ex_hold_c;
        id_ex_flush  = rst_n & id_ex_flush_c;
        ex_mem_hold  = rst_n & ex_mem_hold_c;
        ex_mem_flush = rst_n & ex_mem_flush_c;
        redirect_en  = rst_n & redirect_en_c;
        mem_timeout  = rst_n & mem_timeout_c;
    end

    always_comb begin
        stall_d = stall_q;
        if (pc_hold && (stall_q != '1)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            tmo_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + randomized bench for pipeline_hazard_ctrl against a behavioural model
// of the stall/redirect rules, the wait timeout and the saturating stall counter.
`ifndef REG_FILE_ADDR_WIDTH
`define REG_FILE_ADDR_WIDTH 5
`endif

module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO = 4;
    localparam int AW = `REG_FILE_ADDR_WIDTH;

    logic          clk;
    logic          rst_n;
    logic          reg_1_valid, reg_2_valid;
    logic [AW-1:0] id_reg_1_idx, id_reg_2_idx, ex_reg_dest_idx;
    logic          ex_mem_read, pc_offset, pc_overload, mem_req, mem_ready;
    logic          pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
    logic          ex_mem_hold, ex_mem_flush, redirect_en, mem_timeout;
    logic [15:0]   stall_cycles;
    logic [1:0]    state;

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .reg_1_valid    (reg_1_valid),
        .reg_2_valid    (reg_2_valid),
        .id_reg_1_idx   (id_reg_1_idx),
        .id_reg_2_idx   (id_reg_2_idx),
        .ex_mem_read    (ex_mem_read),
        .ex_reg_dest_idx(ex_reg_dest_idx),
        .pc_offset      (pc_offset),
        .pc_overload    (pc_overload),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_hold        (pc_hold),
        .if_id_hold     (if_id_hold),
        .if_id_flush    (if_id_flush),
        .id_ex_hold     (id_ex_hold),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_hold    (ex_mem_hold),
        .ex_mem_flush   (ex_mem_flush),
        .redirect_en    (redirect_en),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: 0 = running, 1 = waiting on memory, 2 = abort cycle.
    int m_mode  = 0;
    int m_waits = 0;
    int m_stall = 0;
    int timeout_pulses = 0;

    function automatic logic [8:0] ctrl_vec();
        return {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                ex_mem_hold, ex_mem_flush, redirect_en, mem_timeout};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reg_1_valid = 0; reg_2_valid = 0;
        id_reg_1_idx = '0; id_reg_2_idx = '0; ex_reg_dest_idx = '0;
        ex_mem_read = 0; pc_offset = 0; pc_overload = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    // Called just after a falling edge with inputs set; checks, then advances one cycle.
    task automatic step(input bit do_chk, input string tag);
        bit ms, lu;
        bit eph, eih, eif, eih2, eidf, eemh, eemf, ered, emt;
        #1;
        ms = (m_mode != 2) && mem_req && !mem_ready;
        lu = ex_mem_read && (ex_reg_dest_idx != 0) &&
             ((reg_1_valid && id_reg_1_idx == ex_reg_dest_idx) ||
              (reg_2_valid && id_reg_2_idx == ex_reg_dest_idx));
        {eph, eih, eif, eih2, eidf, eemh, eemf, ered, emt} = '0;
        if (m_mode == 2) begin
            emt = 1; eemf = 1;
            if (lu) begin eph = 1; eih = 1; eidf = 1; end
        end else if (ms) begin
            eph = 1; eih = 1; eih2 = 1; eemh = 1;
        end else if (lu) begin
            eph = 1; eih = 1; eidf = 1;
        end else begin
            ered = 1; eif = pc_offset || pc_overload;
        end
        if (do_chk) begin
            chk({tag, ".ctrl"}, 32'(ctrl_vec()),
                32'({eph, eih, eif, eih2, eidf, eemh, eemf, ered, emt}));
            chk({tag, ".state"}, 32'(state), 32'(m_mode));
            chk({tag, ".stall"}, 32'(stall_cycles), 32'(m_stall));
        end
        if (mem_timeout) timeout_pulses++;
        m_stall = (m_stall + int'(eph) > 65535) ? 65535 : m_stall + int'(eph);
        if (m_mode == 0) begin
            if (ms) begin m_mode = 1; m_waits = 0; end
        end else if (m_mode == 1) begin
            if (mem_ready) m_mode = 0;
            else begin
                m_waits++;
                if (m_waits == int'(TO)) m_mode = 2;
            end
        end else begin
            m_mode = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        mem_req = 1; ex_mem_read = 1; ex_reg_dest_idx = 5;
        reg_1_valid = 1; id_reg_1_idx = 5; pc_offset = 1;
        #2;
        chk("reset.ctrl", 32'(ctrl_vec()), 32'h0);
        chk("reset.state", 32'(state), 32'h0);
        chk("reset.stall", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        rst_n = 1;
        clear_inputs();

        // Load-use with a taken branch: bubble, redirect suppressed.
        ex_mem_read = 1; ex_reg_dest_idx = 5; reg_1_valid = 1; id_reg_1_idx = 5; pc_offset = 1;
        step(1, "load_use");
        chk("load_use.stall_inc", 32'(stall_cycles), 32'd1);

        // Destination $0 never creates a hazard.
        ex_reg_dest_idx = 0; id_reg_1_idx = 0;
        step(1, "dest_zero");

        // Jump via reg 2 path, no hazard.
        clear_inputs(); pc_overload = 1; reg_2_valid = 1; id_reg_2_idx = 3;
        ex_mem_read = 1; ex_reg_dest_idx = 4;
        step(1, "jump");

        // Memory wait: three not-ready cycles then ready.
        begin
            int base;
            clear_inputs();
            base = m_stall;
            mem_req = 1;
            for (int i = 0; i < 3; i++) step(1, "mem_wait");
            mem_ready = 1;
            step(1, "mem_ready");
            clear_inputs();
            step(1, "after_wait");
            chk("mem_wait.stall_delta", 32'(stall_cycles) - 32'(base), 32'd3);
        end

        // Timeout: abort after TO waiting cycles, then wait re-entered.
        timeout_pulses = 0;
        clear_inputs(); mem_req = 1;
        for (int i = 0; i < 8; i++) step(1, "timeout");
        chk("timeout.pulses", 32'(timeout_pulses), 32'd1);

        // Drain, then abort cycle overlapping a load-use hazard.
        mem_ready = 1; step(1, "drain");
        clear_inputs(); mem_req = 1;
        for (int i = 0; i < 4; i++) step(1, "abort_lu_pre");
        ex_mem_read = 1; ex_reg_dest_idx = 7; reg_2_valid = 1; id_reg_2_idx = 7;
        step(1, "abort_lu_last_wait");
        step(1, "abort_lu");
        clear_inputs(); step(1, "abort_lu_post");

        // Ready arrives on the would-be timeout cycle: no abort.
        timeout_pulses = 0;
        mem_req = 1;
        for (int i = 0; i < 4; i++) step(1, "race");
        mem_ready = 1; step(1, "race_ready");
        clear_inputs(); step(1, "race_post");
        chk("race.pulses", 32'(timeout_pulses), 32'd0);

        // Reset pulsed mid-wait.
        mem_req = 1;
        for (int i = 0; i < 3; i++) step(1, "pre_reset");
        #2 rst_n = 0;
        #1;
        chk("mid_reset.ctrl", 32'(ctrl_vec()), 32'h0);
        chk("mid_reset.state", 32'(state), 32'h0);
        chk("mid_reset.stall", 32'(stall_cycles), 32'h0);
        m_mode = 0; m_waits = 0; m_stall = 0;
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
        step(1, "post_reset");

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            reg_1_valid     = $urandom_range(0, 1);
            reg_2_valid     = $urandom_range(0, 1);
            id_reg_1_idx    = AW'($urandom_range(0, 3));
            id_reg_2_idx    = AW'($urandom_range(0, 3));
            ex_reg_dest_idx = AW'($urandom_range(0, 3));
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            pc_offset       = ($urandom_range(0, 3) == 0);
            pc_overload     = ($urandom_range(0, 5) == 0);
            mem_req         = $urandom_range(0, 1);
            mem_ready       = ($urandom_range(0, 3) == 0);
            step(1, "rand");
        end

        // Saturation: hold a load-use hazard long enough to fill the counter.
        clear_inputs();
        ex_mem_read = 1; ex_reg_dest_idx = 2; reg_1_valid = 1; id_reg_1_idx = 2;
        for (int i = 0; i < 65540; i++) step(0, "sat");
        step(1, "saturate");
        chk("saturate.value", 32'(stall_cycles), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the number of consecutive MEM_WAIT cycles before abort (legal range 1..255).
REQ-002 The block SHALL have ports, one per line (width in bits):
  clk  input  1  system clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  reg_1_valid  input  1  ID instruction reads source register 1
  reg_2_valid  input  1  ID instruction reads source register 2
  id_reg_1_idx  input  `REG_FILE_ADDR_WIDTH  ID source register 1 index
  id_reg_2_idx  input  `REG_FILE_ADDR_WIDTH  ID source register 2 index
  ex_mem_read  input  1  instruction in EX is a load
  ex_reg_dest_idx  input  `REG_FILE_ADDR_WIDTH  EX destination register index
  pc_offset  input  1  ID branch taken
  pc_overload  input  1  ID jump (j/jal/jr)
  mem_req  input  1  MEM stage has an access in flight
  mem_ready  input  1  memory/IO access completes this cycle
  pc_hold  output  1  freeze PC
  if_id_hold  output  1  freeze if_id_reg
  if_id_flush  output  1  clear if_id_reg to bubble
  id_ex_hold  output  1  freeze id_ex_reg
  id_ex_flush  output  1  insert bubble into id_ex_reg
  ex_mem_hold  output  1  freeze ex_mem_reg
  ex_mem_flush  output  1  insert bubble into ex_mem_reg
  redirect_en  output  1  allow PC offset/overload this cycle
  mem_timeout  output  1  one-cycle abort pulse
  stall_cycles  output  16  saturating count of stalled cycles
  state  output  2  current FSM state (debug)

Function
REQ-003 The FSM SHALL have states RUN=2'b00, WAIT=2'b01, ABORT=2'b10; 2'b11 SHALL transition to RUN next cycle with all controls deasserted.
REQ-004 All control outputs SHALL be combinational from state and current inputs (same-cycle effect); state, timeout counter and stall_cycles SHALL be registered.
REQ-005 mem_stall SHALL be mem_req & ~mem_ready in states RUN or WAIT, and 0 in ABORT.
REQ-006 load_use SHALL be ex_mem_read & (ex_reg_dest_idx != 0) & ((reg_1_valid & id_reg_1_idx == ex_reg_dest_idx) | (reg_2_valid & id_reg_2_idx == ex_reg_dest_idx)).
REQ-007 Priority SHALL be mem_stall > load_use > redirect.
REQ-008 When mem_stall, pc_hold, if_id_hold, id_ex_hold, ex_mem_hold SHALL be 1 and all flushes and redirect_en SHALL be 0.
REQ-009 When load_use and not mem_stall, pc_hold=if_id_hold=id_ex_flush=1, redirect_en=0, all others 0 (one-cycle bubble; branch using stale operand suppressed).
REQ-010 When neither stall, redirect_en SHALL be 1; if pc_offset|pc_overload, if_id_flush SHALL be 1 in the same cycle.
REQ-011 RUN->WAIT SHALL occur when mem_stall; WAIT->RUN when mem_ready; RUN stays otherwise.
REQ-012 An 8-bit timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle with mem_ready=0; when it reaches TIMEOUT_CYCLES with mem_ready=0, next state SHALL be ABORT.
REQ-013 mem_ready and timeout in the same cycle: mem_ready SHALL win (WAIT->RUN, no abort).
REQ-014 In ABORT (exactly one cycle): mem_timeout=1, ex_mem_flush=1, all holds 0, redirect_en=0, if_id_flush=0; next state RUN regardless of inputs; load_use SHALL still apply in ABORT (id_ex_flush, pc_hold, if_id_hold).
REQ-015 stall_cycles SHALL increment by 1 each cycle pc_hold=1, saturating at 16'hFFFF.
REQ-016 mem_timeout SHALL never be asserted outside ABORT.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state=RUN, timeout counter=0, stall_cycles=0; while rst_n=0 all control outputs SHALL be 0, including mid-WAIT.
REQ-018 First rising edge after rst_n deasserts SHALL evaluate as RUN.

Verification
REQ-019 Load-use: ex_mem_read=1, ex_reg_dest_idx=5, reg_1_valid=1, id_reg_1_idx=5, pc_offset=1 -> pc_hold=if_id_hold=id_ex_flush=1, redirect_en=0, if_id_flush=0, stall_cycles +1.
REQ-020 Dest $0: same as REQ-019 with indices 0 -> no stall, redirect_en=1, if_id_flush=1.
REQ-021 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> state WAIT for 3 cycles, all four holds 1 for 3 cycles, release in ready cycle, RUN next, stall_cycles=3.
REQ-022 Timeout: TIMEOUT_CYCLES=4, mem_req=1, mem_ready=0 held -> ABORT after 4 WAIT cycles, mem_timeout and ex_mem_flush 1 for exactly one cycle, then RUN (and WAIT re-entered if mem_req persists).
REQ-023 Race/reset: mem_ready=1 on the timeout cycle -> RUN, no mem_timeout; rst_n pulsed low mid-WAIT -> outputs 0 immediately, stall_cycles=0, state RUN.
REQ-024 Saturation: pc_hold held for 65536+ cycles -> stall_cycles stays 16'hFFFF.
